// File: rtl/ctrl_decode_pipe_if.sv
// Instruction-side and result-side signals of the pipelined control decoder.
// master drives instructions and pipeline control; slave is the decoder.
interface ctrl_decode_pipe_if;
  logic       valid_in;
  logic       in_ready;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic       s_bit;
  logic [3:0] cond;
  logic [3:0] status;
  logic       stall;
  logic       flush;
  logic [8:0] ctrl_res;
  logic       valid_out;
  logic       busy;

  modport master (
    output valid_in, mode, op_code, s_bit, cond, status, stall, flush,
    input  in_ready, ctrl_res, valid_out, busy
  );

  modport slave (
    input  valid_in, mode, op_code, s_bit, cond, status, stall, flush,
    output in_ready, ctrl_res, valid_out, busy
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decoder with ARM condition check, DEPTH registered stages,
// stall/flush, and a down-counter FSM that sequences multi-cycle multiplies.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | normal decode; words go straight into stage 0
// ST_MUL  | multiply word parked in hold_q, input blocked, cnt_q counting down
module ctrl_decode_pipe #(
  parameter int         DEPTH      = 1,
  parameter int         MUL_CYCLES = 3,
  parameter logic [3:0] MUL_CMD    = 4'b1111,
  parameter logic [3:0] MEM_CMD    = 4'b0100
) (
  input logic               clk,
  input logic               rst,
  ctrl_decode_pipe_if.slave bus
);

  localparam int CNT_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam bit MUL_MULTI = (MUL_CYCLES > 1);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       hold_q, hold_d;

  logic [8:0]       stage_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [8:0] s0_word;
  logic       s0_vld;
  logic       accept;
  logic       cond_ok;
  logic       mul_start;
  logic [8:0] dec_word;

  logic       wb_en, mem_r_en, mem_w_en, b_fld, s_fld;
  logic [3:0] exe_cmd;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    n  = nzcv[3];
    z  = nzcv[2];
    cf = nzcv[1];
    v  = nzcv[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf && !z;
      4'b1001: cond_pass = !cf || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      default: cond_pass = 1'b1;  // 1110 AL, and 1111 also treated as always
    endcase
  endfunction

  assign bus.in_ready = !bus.stall && (state_q == ST_IDLE) && !bus.flush;
  assign bus.busy     = (state_q == ST_MUL);
  assign accept       = bus.valid_in && bus.in_ready;
  assign cond_ok      = cond_pass(bus.cond, bus.status);
  assign mul_start    = MUL_MULTI && accept && cond_ok && (bus.mode == 2'b11);

  always_comb begin
    wb_en    = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    exe_cmd  = 4'b0000;
    b_fld    = 1'b0;
    s_fld    = 1'b0;
    case (bus.mode)
      2'b00: begin
        exe_cmd = bus.op_code;
        // TST/TEQ/CMP/CMN only update flags
        wb_en   = (bus.op_code[3:2] != 2'b10);
        s_fld   = bus.s_bit;
      end
      2'b01: begin
        exe_cmd = MEM_CMD;
        if (bus.s_bit) begin
          mem_r_en = 1'b1;
          wb_en    = 1'b1;
        end else begin
          mem_w_en = 1'b1;
        end
      end
      2'b10: begin
        b_fld = 1'b1;
      end
      default: begin
        exe_cmd = MUL_CMD;
        wb_en   = 1'b1;
        s_fld   = bus.s_bit;
      end
    endcase
  end

  assign dec_word = {wb_en, mem_r_en, mem_w_en, exe_cmd, b_fld, s_fld};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    s0_word = '0;
    s0_vld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          hold_d  = dec_word;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = ST_MUL;
        end else if (accept && cond_ok) begin
          s0_word = dec_word;
          s0_vld  = 1'b1;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          s0_word = hold_q;
          s0_vld  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      vld_q <= '0;
    end else if (!bus.stall) begin
      stage_q[0] <= s0_word;
      vld_q[0]   <= s0_vld;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
        vld_q[i]   <= vld_q[i-1];
      end
    end
  end

  assign bus.ctrl_res  = stage_q[DEPTH-1];
  assign bus.valid_out = vld_q[DEPTH-1];

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Drives one directed instruction stream into three decoder configurations and
// checks each against an in-flight-item countdown model plus pinned literals.
module tb_ctrl_decode_pipe;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic       s_bit;
  logic [3:0] cond;
  logic [3:0] status;
  logic       stall;
  logic       flush;

  int n_tests = 0;
  int n_fail  = 0;
  bit live    = 0;

  ctrl_decode_pipe_if bus0();
  ctrl_decode_pipe_if bus1();
  ctrl_decode_pipe_if bus2();

  assign bus0.valid_in = valid_in; assign bus1.valid_in = valid_in; assign bus2.valid_in = valid_in;
  assign bus0.mode     = mode;     assign bus1.mode     = mode;     assign bus2.mode     = mode;
  assign bus0.op_code  = op_code;  assign bus1.op_code  = op_code;  assign bus2.op_code  = op_code;
  assign bus0.s_bit    = s_bit;    assign bus1.s_bit    = s_bit;    assign bus2.s_bit    = s_bit;
  assign bus0.cond     = cond;     assign bus1.cond     = cond;     assign bus2.cond     = cond;
  assign bus0.status   = status;   assign bus1.status   = status;   assign bus2.status   = status;
  assign bus0.stall    = stall;    assign bus1.stall    = stall;    assign bus2.stall    = stall;
  assign bus0.flush    = flush;    assign bus1.flush    = flush;    assign bus2.flush    = flush;

  logic [8:0] got_res  [3];
  logic       got_vld  [3];
  logic       got_busy [3];
  logic       got_rdy  [3];

  assign got_res[0] = bus0.ctrl_res; assign got_vld[0] = bus0.valid_out;
  assign got_res[1] = bus1.ctrl_res; assign got_vld[1] = bus1.valid_out;
  assign got_res[2] = bus2.ctrl_res; assign got_vld[2] = bus2.valid_out;
  assign got_busy[0] = bus0.busy; assign got_rdy[0] = bus0.in_ready;
  assign got_busy[1] = bus1.busy; assign got_rdy[1] = bus1.in_ready;
  assign got_busy[2] = bus2.busy; assign got_rdy[2] = bus2.in_ready;

  ctrl_decode_pipe #(.DEPTH(1), .MUL_CYCLES(3), .MUL_CMD(4'b1111), .MEM_CMD(4'b0100))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ctrl_decode_pipe #(.DEPTH(2), .MUL_CYCLES(3), .MUL_CMD(4'b1111), .MEM_CMD(4'b0100))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ctrl_decode_pipe #(.DEPTH(3), .MUL_CYCLES(1), .MUL_CMD(4'b1111), .MEM_CMD(4'b0100))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each live word counts down the unstalled edges left before it shows
  // at ctrl_res; it is visible while its count is 0.
  int         rem   [3][16];
  bit         used  [3][16];
  bit         ismul [3][16];
  logic [8:0] iw    [3][16];

  function automatic int dep(input int k);
    return k + 1;
  endfunction

  function automatic int mcy(input int k);
    return (k == 2) ? 1 : 3;
  endfunction

  function automatic bit m_busy(input int k);
    for (int i = 0; i < 16; i++)
      if (used[k][i] && ismul[k][i] && rem[k][i] >= dep(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  function automatic logic [8:0] m_dec(input logic [1:0] md, input logic [3:0] op, input logic s);
    logic wb, mr, mw, b, so;
    logic [3:0] cmd;
    wb = 0; mr = 0; mw = 0; b = 0; so = 0; cmd = 4'd0;
    if (md == 2'd0) begin
      cmd = op; so = s;
      wb = !(op >= 4'd8 && op <= 4'd11);
    end else if (md == 2'd1) begin
      cmd = 4'b0100; mr = s; wb = s; mw = !s;
    end else if (md == 2'd2) begin
      b = 1;
    end else begin
      cmd = 4'b1111; wb = 1; so = s;
    end
    return {wb, mr, mw, cmd, b, so};
  endfunction

  task automatic m_edge(input int k);
    bit acc, placed;
    if (rst || flush) begin
      for (int i = 0; i < 16; i++) used[k][i] = 0;
    end else if (!stall) begin
      acc = valid_in && !m_busy(k);
      for (int i = 0; i < 16; i++) begin
        if (used[k][i]) begin
          rem[k][i] = rem[k][i] - 1;
          if (rem[k][i] < 0) used[k][i] = 0;
        end
      end
      if (acc && m_cond(cond, status)) begin
        placed = 0;
        for (int i = 0; i < 16; i++) begin
          if (!used[k][i] && !placed) begin
            placed      = 1;
            used[k][i]  = 1;
            ismul[k][i] = (mode == 2'b11) && (mcy(k) > 1);
            rem[k][i]   = ismul[k][i] ? dep(k) + mcy(k) - 2 : dep(k) - 1;
            iw[k][i]    = m_dec(mode, op_code, s_bit);
          end
        end
        if (!placed) begin
          n_fail++;
          $display("FAIL model_overflow dut%0d", k);
        end
      end
    end
  endtask

  task automatic m_out(input int k, output logic [8:0] w, output logic v);
    w = '0; v = 0;
    for (int i = 0; i < 16; i++)
      if (used[k][i] && rem[k][i] == 0) begin
        w = iw[k][i]; v = 1;
      end
  endtask

  task automatic chk(input string nm, input int k, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, k, got, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [8:0] got, input logic [8:0] exp);
    chk(nm, -1, got, exp);
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] md, input logic [3:0] op,
                      input bit s, input logic [3:0] c, input logic [3:0] st,
                      input bit stl, input bit fl);
    logic [8:0] ew;
    logic       ev;
    rst = r; valid_in = v; mode = md; op_code = op; s_bit = s;
    cond = c; status = st; stall = stl; flush = fl;
    @(negedge clk);
    if (live) begin
      for (int k = 0; k < 3; k++) begin
        m_out(k, ew, ev);
        chk("ctrl_res", k, got_res[k], ew);
        chk("valid_out", k, {8'd0, got_vld[k]}, {8'd0, ev});
        chk("busy", k, {8'd0, got_busy[k]}, {8'd0, m_busy(k)});
        chk("in_ready", k, {8'd0, got_rdy[k]}, {8'd0, (!stall && !flush && !m_busy(k))});
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_edge(k);
    if (r) live = 1;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0);
  endtask

  task automatic mul_go();
    step(0, 1, 2'b11, 4'h0, 1, 4'hE, 4'h0, 0, 0);
  endtask

  initial begin
    step(1, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0);
    step(1, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0);
    lit("rst_res", got_res[0], 9'h000);
    lit("rst_vld", {8'd0, got_vld[0]}, 9'd0);
    lit("rst_busy", {8'd0, got_busy[1]}, 9'd0);
    lit("rst_rdy", {8'd0, got_rdy[0]}, 9'd1);

    step(0, 1, 2'b00, 4'b0100, 1, 4'hE, 4'h0, 0, 0);
    lit("add", got_res[0], 9'b1_0_0_0100_0_1);
    lit("add_vld", {8'd0, got_vld[0]}, 9'd1);
    step(0, 1, 2'b00, 4'b1010, 0, 4'hE, 4'h0, 0, 0);
    lit("cmp", got_res[0], 9'b0_0_0_1010_0_0);
    step(0, 1, 2'b01, 4'b0000, 0, 4'hE, 4'h0, 0, 0);
    lit("str", got_res[0], 9'b0_0_1_0100_0_0);
    step(0, 1, 2'b10, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
    lit("beq_fail_vld", {8'd0, got_vld[0]}, 9'd0);
    lit("beq_fail_res", got_res[0], 9'h000);
    step(0, 1, 2'b10, 4'b0000, 0, 4'b0000, 4'b0100, 0, 0);
    lit("beq_pass", got_res[0], 9'b0_0_0_0000_1_0);
    repeat (3) idle();

    for (int c = 0; c < 16; c++) begin
      step(0, 1, 2'b10, 4'h0, 0, 4'(c), 4'h0, 0, 0);
      step(0, 1, 2'b10, 4'h0, 0, 4'(c), 4'h6, 0, 0);
      step(0, 1, 2'b10, 4'h0, 0, 4'(c), 4'h9, 0, 0);
      step(0, 1, 2'b10, 4'h0, 0, 4'(c), 4'hA, 0, 0);
    end
    for (int op = 0; op < 16; op++) step(0, 1, 2'b00, 4'(op), op[0], 4'hE, 4'h0, 0, 0);
    step(0, 1, 2'b01, 4'h0, 1, 4'hE, 4'h0, 0, 0);
    lit("ldr", got_res[0], 9'b1_1_0_0100_0_0);
    repeat (3) idle();

    mul_go();
    lit("mul_busy_t1", {8'd0, got_busy[1]}, 9'd1);
    lit("mul_rdy_t1", {8'd0, got_rdy[1]}, 9'd0);
    idle();
    lit("mul_busy_t2", {8'd0, got_busy[1]}, 9'd1);
    idle();
    lit("mul_busy_t3", {8'd0, got_busy[1]}, 9'd0);
    lit("mul_vld_t3", {8'd0, got_vld[1]}, 9'd0);
    lit("mul_d1_t3", got_res[0], 9'b1_0_0_1111_0_1);
    idle();
    lit("mul_res_t4", got_res[1], 9'b1_0_0_1111_0_1);
    lit("mul_vld_t4", {8'd0, got_vld[1]}, 9'd1);
    idle();
    lit("mul_vld_t5", {8'd0, got_vld[1]}, 9'd0);
    idle();

    mul_go();
    step(0, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 1, 0);
    step(0, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 1, 0);
    idle();
    lit("mstall_busy_t4", {8'd0, got_busy[1]}, 9'd1);
    idle();
    lit("mstall_vld_t5", {8'd0, got_vld[1]}, 9'd0);
    idle();
    lit("mstall_res_t6", got_res[1], 9'b1_0_0_1111_0_1);
    lit("mstall_vld_t6", {8'd0, got_vld[1]}, 9'd1);
    repeat (2) idle();

    mul_go();
    lit("mflush_busy_t1", {8'd0, got_busy[1]}, 9'd1);
    step(0, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 1);
    lit("mflush_busy_t2", {8'd0, got_busy[1]}, 9'd0);
    for (int i = 0; i < 4; i++) begin
      lit("mflush_vld", {8'd0, got_vld[1]}, 9'd0);
      idle();
    end

    step(0, 1, 2'b11, 4'h0, 1, 4'b0000, 4'h0, 0, 0);
    lit("mul_condfail_busy", {8'd0, got_busy[1]}, 9'd0);
    idle();
    mul_go();
    lit("mrst_busy_pre", {8'd0, got_busy[0]}, 9'd1);
    step(1, 0, 2'b00, 4'h0, 0, 4'hE, 4'h0, 0, 0);
    lit("mrst_busy", {8'd0, got_busy[0]}, 9'd0);
    lit("mrst_res", got_res[0], 9'h000);
    repeat (4) idle();

    step(0, 1, 2'b00, 4'b0100, 0, 4'hE, 4'h0, 0, 0);
    step(0, 1, 2'b00, 4'b0010, 0, 4'hE, 4'h0, 0, 0);
    step(0, 1, 2'b01, 4'h0, 1, 4'hE, 4'h0, 1, 0);
    step(0, 1, 2'b01, 4'h0, 1, 4'hE, 4'h0, 0, 0);
    lit("d3_add", got_res[2], 9'b1_0_0_0100_0_0);
    lit("d3_add_vld", {8'd0, got_vld[2]}, 9'd1);
    idle();
    lit("d3_sub", got_res[2], 9'b1_0_0_0010_0_0);
    idle();
    lit("d3_ldr", got_res[2], 9'b1_1_0_0100_0_0);
    idle();
    lit("d3_drain", {8'd0, got_vld[2]}, 9'd0);

    step(0, 1, 2'b00, 4'b0100, 1, 4'hE, 4'h0, 0, 1);
    lit("flush_noacc", {8'd0, got_vld[0]}, 9'd0);
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
